// File: rtl/pulse_period_timer.sv
// pulse_period_timer
// Measures the time between successive rising edges of an asynchronous
// mechanism signal, counted in tick-qualified clock cycles. Results are
// handed off over a valid/ready handshake; glitches shorter than MIN_COUNT
// ticks are ignored, and a missing closing edge raises a timeout pulse.

module pulse_period_timer #(
    parameter int MAX_COUNT = 65535,
    parameter int MIN_COUNT = 2,
    localparam int W = $clog2(MAX_COUNT + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         tick,
    input  logic         signal_in,
    output logic [W-1:0] period,
    output logic         period_valid,
    input  logic         period_ready,
    output logic         timeout,
    output logic         overrun,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam logic [W-1:0] MAX_W   = W'(MAX_COUNT);
    localparam logic [W-1:0] MIN_W   = W'(MIN_COUNT);
    localparam logic [W:0]   MAX_EXT = (W+1)'(MAX_COUNT);

    state_t       state;
    logic [W-1:0] count;
    logic         sync_a;
    logic         synced;
    logic         prev;

    logic         edge_det;
    logic [W:0]   count_sum;
    logic [W-1:0] sat_next;
    logic         capture;

    // Two-flop synchroniser followed by the edge-detect history flop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a <= 1'b0;
            synced <= 1'b0;
            prev   <= 1'b0;
        end else begin
            sync_a <= signal_in;
            synced <= sync_a;
            prev   <= synced;
        end
    end

    // Rising edge of the synchronised input, saturating increment, and the
    // condition under which a closing edge produces a result
    always_comb begin
        edge_det  = synced & ~prev;
        count_sum = {1'b0, count} + (W+1)'(tick);
        sat_next  = (count_sum > MAX_EXT) ? MAX_W : count_sum[W-1:0];
        capture   = enable && (state == MEASURE) && edge_det && (sat_next >= MIN_W);
    end

    // Sequencer: IDLE -> ARMED -> MEASURE, result capture and handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            count        <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            overrun      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            timeout <= 1'b0;
            overrun <= 1'b0;

            // Result register: a new capture wins over a same-cycle accept
            if (capture) begin
                period       <= sat_next;
                period_valid <= 1'b1;
                overrun      <= period_valid & ~period_ready;
            end else if (period_valid && period_ready) begin
                period_valid <= 1'b0;
            end

            if (!enable) begin
                // Disable dominates edges and timeouts; pending result survives
                state <= IDLE;
                count <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        count <= '0;
                        state <= ARMED;
                        busy  <= 1'b0;
                    end
                    ARMED: begin
                        count <= '0;
                        if (edge_det) begin
                            state <= MEASURE;
                            busy  <= 1'b1;
                        end
                    end
                    MEASURE: begin
                        if (capture) begin
                            // Closing edge also opens the next period
                            count <= '0;
                        end else if (edge_det) begin
                            // Too short to be a real period: keep counting
                            count <= sat_next;
                        end else if ((count == MAX_W) && tick) begin
                            timeout <= 1'b1;
                            count   <= '0;
                            state   <= ARMED;
                            busy    <= 1'b0;
                        end else begin
                            count <= sat_next;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        count <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
